waveform_meter: RTL and testbench

//  Downstream consumer of the divided-clock generators. Samples one

---
 rtl/waveform_meter_pkg.sv | 15 +
 rtl/waveform_meter_sync_edge_detect.sv | 31 +++
 rtl/waveform_meter.sv | 187 ++++++++++++++++++
 tb/tb_waveform_meter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/waveform_meter_pkg.sv
// Shared types and default sizing for the waveform meter.
package waveform_meter_pkg;

  // Measurement FSM: idle until a rise, then track the high and low phases.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHigh = 2'd1,
    StLow  = 2'd2
  } meter_state_e;

  localparam int unsigned CntWDefault       = 16;
  localparam int unsigned SyncStagesDefault = 2;
  localparam int unsigned TimeoutDefault    = 1024;

endpackage

// File: rtl/waveform_meter_sync_edge_detect.sv
// Synchronizes an asynchronous level and flags its rising and falling edges.
module waveform_meter_sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d_async,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_d_q;

  // Synchronizer chain plus one extra flop holding the previous synced level.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync_q    <= '0;
      level_d_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], d_async};
      level_d_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~level_d_q;
  assign fall  = ~level & level_d_q;

endmodule

// File: rtl/waveform_meter.sv
// Measures high time, low time and period of an asynchronous waveform in
// clock cycles, and flags a waveform that stops toggling.
module waveform_meter
  import waveform_meter_pkg::*;
#(
  parameter int unsigned CNT_W       = CntWDefault,
  parameter int unsigned SYNC_STAGES = SyncStagesDefault,
  parameter int unsigned TIMEOUT     = TimeoutDefault
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             sig_in,
  output logic             meas_valid,
  output logic [CNT_W-1:0] high_time,
  output logic [CNT_W-1:0] low_time,
  output logic [CNT_W:0]   period,
  output logic             meas_sat,
  output logic             stuck,
  output logic             stuck_level
);

  // Timeout counter is sized from TIMEOUT alone so it never limits CNT_W.
  localparam int unsigned        TcntW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TcntW-1:0]   TcntLast = TcntW'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   CntMax   = {CNT_W{1'b1}};

  logic level, rise, fall;

  meter_state_e     state_q, state_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] lcnt_q, lcnt_d;
  logic [TcntW-1:0] tcnt_q, tcnt_d;
  logic             sat_q, sat_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] low_q, low_d;
  logic [CNT_W:0]   period_q, period_d;
  logic             msat_q, msat_d;
  logic             valid_q, valid_d;
  logic             stuck_q, stuck_d;
  logic             slevel_q, slevel_d;

  waveform_meter_sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clock  (clock),
    .reset_n(reset_n),
    .d_async(sig_in),
    .level  (level),
    .rise   (rise),
    .fall   (fall)
  );

  // Next-state logic: enable low overrides everything, an edge beats a timeout.
  always_comb begin
    state_d  = state_q;
    hcnt_d   = hcnt_q;
    lcnt_d   = lcnt_q;
    tcnt_d   = tcnt_q;
    sat_d    = sat_q;
    high_d   = high_q;
    low_d    = low_q;
    period_d = period_q;
    msat_d   = msat_q;
    valid_d  = 1'b0;
    stuck_d  = stuck_q;
    slevel_d = slevel_q;

    if (!enable) begin
      state_d = StIdle;
      hcnt_d  = '0;
      lcnt_d  = '0;
      tcnt_d  = '0;
      sat_d   = 1'b0;
    end else begin
      if (rise || fall) begin
        stuck_d = 1'b0;
      end
      case (state_q)
        StIdle: begin
          if (rise) begin
            state_d = StHigh;
            hcnt_d  = CNT_W'(1);
            lcnt_d  = '0;
            tcnt_d  = '0;
            sat_d   = 1'b0;
          end
        end
        StHigh: begin
          if (fall) begin
            state_d = StLow;
            lcnt_d  = CNT_W'(1);
            tcnt_d  = '0;
          end else if (tcnt_q == TcntLast) begin
            state_d  = StIdle;
            stuck_d  = 1'b1;
            slevel_d = level;
            hcnt_d   = '0;
            lcnt_d   = '0;
            tcnt_d   = '0;
            sat_d    = 1'b0;
          end else begin
            if (hcnt_q == CntMax) begin
              sat_d = 1'b1;
            end else begin
              hcnt_d = hcnt_q + CNT_W'(1);
            end
            tcnt_d = tcnt_q + TcntW'(1);
          end
        end
        StLow: begin
          if (rise) begin
            // Rise closes a full period: publish it and start the next high phase.
            state_d  = StHigh;
            high_d   = hcnt_q;
            low_d    = lcnt_q;
            period_d = {1'b0, hcnt_q} + {1'b0, lcnt_q};
            msat_d   = sat_q;
            valid_d  = 1'b1;
            hcnt_d   = CNT_W'(1);
            lcnt_d   = '0;
            tcnt_d   = '0;
            sat_d    = 1'b0;
          end else if (tcnt_q == TcntLast) begin
            state_d  = StIdle;
            stuck_d  = 1'b1;
            slevel_d = level;
            hcnt_d   = '0;
            lcnt_d   = '0;
            tcnt_d   = '0;
            sat_d    = 1'b0;
          end else begin
            if (lcnt_q == CntMax) begin
              sat_d = 1'b1;
            end else begin
              lcnt_d = lcnt_q + CNT_W'(1);
            end
            tcnt_d = tcnt_q + TcntW'(1);
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // State and result registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      hcnt_q   <= '0;
      lcnt_q   <= '0;
      tcnt_q   <= '0;
      sat_q    <= 1'b0;
      high_q   <= '0;
      low_q    <= '0;
      period_q <= '0;
      msat_q   <= 1'b0;
      valid_q  <= 1'b0;
      stuck_q  <= 1'b0;
      slevel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hcnt_q   <= hcnt_d;
      lcnt_q   <= lcnt_d;
      tcnt_q   <= tcnt_d;
      sat_q    <= sat_d;
      high_q   <= high_d;
      low_q    <= low_d;
      period_q <= period_d;
      msat_q   <= msat_d;
      valid_q  <= valid_d;
      stuck_q  <= stuck_d;
      slevel_q <= slevel_d;
    end
  end

  assign meas_valid  = valid_q;
  assign high_time   = high_q;
  assign low_time    = low_q;
  assign period      = period_q;
  assign meas_sat    = msat_q;
  assign stuck       = stuck_q;
  assign stuck_level = slevel_q;

endmodule

// File: tb/tb_waveform_meter.sv
// Self-checking bench for waveform_meter: edge-timestamp model plus directed
// literal checks and a randomized high/low width run.
module tb_waveform_meter;

  localparam int unsigned CNT_W   = 5;
  localparam int unsigned SYNC    = 2;
  localparam int unsigned TIMEOUT = 60;
  localparam int          CMAX    = 31;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             enable;
  logic             sig_in;
  logic             meas_valid;
  logic [CNT_W-1:0] high_time;
  logic [CNT_W-1:0] low_time;
  logic [CNT_W:0]   period;
  logic             meas_sat;
  logic             stuck;
  logic             stuck_level;

  waveform_meter #(
    .CNT_W      (CNT_W),
    .SYNC_STAGES(SYNC),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (enable),
    .sig_in     (sig_in),
    .meas_valid (meas_valid),
    .high_time  (high_time),
    .low_time   (low_time),
    .period     (period),
    .meas_sat   (meas_sat),
    .stuck      (stuck),
    .stuck_level(stuck_level)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  int n_valid  = 0;
  int cyc      = 0;
  int last_v   = -1;
  int prev_v   = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Model: tracks synced edge timestamps; a result is the gap rise->fall and
  // fall->rise inside one uninterrupted enabled run.
  int   hist [0:SYNC+1];
  bit   m_init = 0;
  bit   m_active = 0;
  int   m_rise_t, m_fall_t, m_edge_t;
  int   m_lvl, m_prv, h_raw, l_raw;
  logic exp_valid, exp_sat, exp_stuck, exp_level;
  int   exp_high, exp_low, exp_period;

  always @(posedge clock) begin
    cyc++;
    exp_valid = 1'b0;
    if (!reset_n) begin
      for (int i = 0; i <= SYNC + 1; i++) hist[i] = 0;
      m_init = 1; m_active = 0;
      m_rise_t = 0; m_fall_t = 0; m_edge_t = 0;
      exp_sat = 0; exp_stuck = 0; exp_level = 0;
      exp_high = 0; exp_low = 0; exp_period = 0;
    end else begin
      for (int i = SYNC + 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = int'(sig_in);
      m_lvl = hist[SYNC];
      m_prv = hist[SYNC+1];
      if (!enable) begin
        m_active = 0;
      end else begin
        if (m_lvl != m_prv) exp_stuck = 1'b0;
        if (m_lvl == 1 && m_prv == 0) begin
          if (m_active && m_fall_t > m_rise_t) begin
            h_raw      = m_fall_t - m_rise_t;
            l_raw      = cyc - m_fall_t;
            exp_high   = (h_raw > CMAX) ? CMAX : h_raw;
            exp_low    = (l_raw > CMAX) ? CMAX : l_raw;
            exp_period = exp_high + exp_low;
            exp_sat    = (h_raw > CMAX) || (l_raw > CMAX);
            exp_valid  = 1'b1;
          end
          m_active = 1; m_rise_t = cyc; m_edge_t = cyc;
        end else if (m_lvl == 0 && m_prv == 1) begin
          if (m_active) begin
            m_fall_t = cyc; m_edge_t = cyc;
          end
        end else if (m_active && (cyc - m_edge_t) == int'(TIMEOUT)) begin
          exp_stuck = 1'b1; exp_level = m_lvl[0]; m_active = 0;
        end
      end
    end
  end

  // Compare every output against the model each cycle once reset has been seen.
  always @(negedge clock) begin
    if (m_init) begin
      chk("meas_valid", meas_valid, exp_valid);
      chk("high_time", high_time, exp_high);
      chk("low_time", low_time, exp_low);
      chk("period", period, exp_period);
      chk("meas_sat", meas_sat, exp_sat);
      chk("stuck", stuck, exp_stuck);
      chk("stuck_level", stuck_level, exp_level);
      if (meas_valid === 1'b1) begin
        n_valid++; prev_v = last_v; last_v = cyc;
      end
    end
  end

  task automatic drive(input logic lvl, input int n);
    sig_in = lvl;
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_valid();
    bit got = 0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clock); #1;
      if (meas_valid === 1'b1) got = 1;
    end
    chk("valid_seen", got, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: no finish, %0d/%0d checks passed so far", n_pass, n_checks);
    $fatal(1);
  end

  int nv0, k;

  initial begin
    reset_n = 1'b0; enable = 1'b0; sig_in = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    chk("reset_valid", meas_valid, 0);
    chk("reset_high", high_time, 0);
    chk("reset_period", period, 0);
    chk("reset_stuck", stuck, 0);
    reset_n = 1'b1; enable = 1'b1;

    // Divide-by-3, duty 2/3.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 2); drive(1'b0, 1);
    end
    sig_in = 1'b1;
    wait_valid();
    chk("t1_high", high_time, 2);
    chk("t1_low", low_time, 1);
    chk("t1_period", period, 3);
    chk("t1_sat", meas_sat, 0);
    chk("t1_count", n_valid, 6);

    // 5 high / 7 low.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5); drive(1'b0, 7);
    end
    sig_in = 1'b1;
    wait_valid();
    chk("t2_high", high_time, 5);
    chk("t2_low", low_time, 7);
    chk("t2_period", period, 12);
    chk("t2_spacing", last_v - prev_v, 12);

    // High phase longer than the counter range.
    drive(1'b1, 40); drive(1'b0, 3);
    sig_in = 1'b1;
    wait_valid();
    chk("t3_high", high_time, CMAX);
    chk("t3_low", low_time, 3);
    chk("t3_period", period, CMAX + 3);
    chk("t3_sat", meas_sat, 1);
    drive(1'b1, 3); drive(1'b0, 4);
    sig_in = 1'b1;
    wait_valid();
    chk("t3_low_next", low_time, 4);
    chk("t3_sat_next", meas_sat, 0);

    // Stuck high after a rise.
    drive(1'b0, 5);
    sig_in = 1'b1;
    wait_valid();
    nv0 = n_valid;
    k = 0;
    while (stuck !== 1'b1 && k < 200) begin
      @(negedge clock); #1; k++;
    end
    chk("t4_stuck_delay", k, TIMEOUT);
    chk("t4_stuck_level", stuck_level, 1);
    chk("t4_no_valid", n_valid - nv0, 0);
    sig_in = 1'b0;
    k = 0;
    while (stuck !== 1'b0 && k < 20) begin
      @(negedge clock); #1; k++;
    end
    chk("t4_clear_delay", k, SYNC + 1);

    // Enable dropped mid-low, then re-enabled.
    drive(1'b1, 4); drive(1'b0, 3); drive(1'b1, 4); drive(1'b0, 5);
    #1; nv0 = n_valid;
    enable = 1'b0;
    drive(1'b0, 3); drive(1'b1, 3); drive(1'b0, 3);
    #1;
    chk("t5_no_valid_off", n_valid - nv0, 0);
    chk("t5_hold_high", high_time, 4);
    chk("t5_hold_low", low_time, 3);
    chk("t5_hold_period", period, 7);
    enable = 1'b1;
    drive(1'b0, 2); drive(1'b1, 3); drive(1'b0, 2);
    #1;
    chk("t5_no_valid_first", n_valid - nv0, 0);
    sig_in = 1'b1;
    wait_valid();
    chk("t5_high", high_time, 3);
    chk("t5_low", low_time, 2);
    chk("t5_period", period, 5);

    // Reset while high.
    drive(1'b1, 2);
    reset_n = 1'b0;
    @(negedge clock); #1;
    chk("t5_rst_valid", meas_valid, 0);
    chk("t5_rst_high", high_time, 0);
    chk("t5_rst_low", low_time, 0);
    chk("t5_rst_period", period, 0);
    reset_n = 1'b1;
    drive(1'b0, 3);

    // Random widths, with occasional short enable drops.
    for (int i = 0; i < 250; i++) begin
      drive(1'b1, $urandom_range(1, 40));
      drive(1'b0, $urandom_range(1, 40));
      if ($urandom_range(0, 19) == 0) begin
        enable = 1'b0;
        repeat ($urandom_range(1, 5)) @(negedge clock);
        enable = 1'b1;
      end
    end
    drive(1'b0, 8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
